// File: rtl/emif_init_sequencer.sv
// DDR4 EMIF bring-up and recovery sequencer: PLL lock, local reset request, calibration tracking with
// retry/backoff, then SoC reset release. Define EMIF_SEQ_CAL_TIMEOUT_EN to bound WAIT_DONE/WAIT_CAL by CAL_TIMEOUT.
module emif_init_sequencer #(
  parameter int REQ_PULSE      = 16,
  parameter int CAL_TIMEOUT    = 1048576,
  parameter int SETTLE_CYCLES  = 64,
  parameter int BACKOFF_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       local_reset_done_i,
  input  logic       cal_success_i,
  input  logic       cal_fail_i,
  input  logic       usr_reset_n_i,
  input  logic       restart_i,
  output logic       local_reset_req_o,
  output logic       sys_rst_no,
  output logic       ready_o,
  output logic       error_o,
  output logic [3:0] retry_cnt_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_WAIT_PLL  = 4'd0,
    S_RESET_REQ = 4'd1,
    S_WAIT_DONE = 4'd2,
    S_WAIT_CAL  = 4'd3,
    S_WAIT_USR  = 4'd4,
    S_SETTLE    = 4'd5,
    S_RUN       = 4'd6,
    S_BACKOFF   = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
  localparam bit CAL_EN = 1'b1;
`else
  localparam bit CAL_EN = 1'b0;
`endif

  localparam int SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int MAX_R_INT = (MAX_RETRIES < 1) ? 1 : ((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);
  localparam logic [3:0] MAX_R = 4'(MAX_R_INT);

  localparam int MAX_A     = (REQ_PULSE > SETTLE_CYCLES) ? REQ_PULSE : SETTLE_CYCLES;
  localparam int MAX_B     = (MAX_A > BACKOFF_CYCLES) ? MAX_A : BACKOFF_CYCLES;
  localparam int CAL_SIZE  = CAL_EN ? CAL_TIMEOUT : 0;
  localparam int TIMER_MAX = (MAX_B > CAL_SIZE) ? MAX_B : CAL_SIZE;
  localparam int TW        = $clog2(TIMER_MAX) + 1;

  // Timer counts down to zero inclusive, so each state lasts exactly (load + 1) cycles.
  localparam logic [TW-1:0] LD_REQ     = TW'(REQ_PULSE - 1);
  localparam logic [TW-1:0] LD_SETTLE  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_BACKOFF = TW'(BACKOFF_CYCLES - 1);
`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
  localparam logic [TW-1:0] LD_CAL     = TW'(CAL_TIMEOUT - 1);
`endif

  localparam int N_IN    = 5;
  localparam int IDX_PLL = 0;
  localparam int IDX_DON = 1;
  localparam int IDX_COK = 2;
  localparam int IDX_CFL = 3;
  localparam int IDX_USR = 4;

  logic [N_IN-1:0] w_async;
  logic [N_IN-1:0] w_sync;

  assign w_async = {usr_reset_n_i, cal_fail_i, cal_success_i, local_reset_done_i, pll_locked_i};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_sync
      logic [SYNC_N-1:0] r_chain;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_chain <= '0;
        end else begin
          r_chain <= {r_chain[SYNC_N-2:0], w_async[gi]};
        end
      end
      assign w_sync[gi] = r_chain[SYNC_N-1];
    end
  endgenerate

  logic w_pll;
  logic w_done;
  logic w_cal_ok;
  logic w_cal_fail;
  logic w_usr;

  assign w_pll      = w_sync[IDX_PLL];
  assign w_done     = w_sync[IDX_DON];
  assign w_cal_ok   = w_sync[IDX_COK];
  assign w_cal_fail = w_sync[IDX_CFL];
  assign w_usr      = w_sync[IDX_USR];

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [TW-1:0] w_timer_load;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_next;
  logic [3:0]    w_retry_sat;
  logic          w_fail;
  logic          w_timer_zero;
  logic          r_req;
  logic          r_sys_rst_n;
  logic          r_ready;
  logic          r_error;

  assign w_timer_zero = (r_timer == '0);
  assign w_retry_sat  = (r_retry == 4'hF) ? 4'hF : (r_retry + 4'd1);

  always_comb begin
    w_state_next = r_state;
    w_fail       = 1'b0;

    case (r_state)
      S_WAIT_PLL: begin
        if (w_pll) w_state_next = S_RESET_REQ;
      end
      S_RESET_REQ: begin
        if (w_timer_zero) w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done) w_state_next = S_WAIT_CAL;
`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
        else if (w_timer_zero) w_fail = 1'b1;
`endif
      end
      S_WAIT_CAL: begin
        // A simultaneous fail and success is treated as a failed calibration.
        if (w_cal_fail) w_fail = 1'b1;
        else if (w_cal_ok) w_state_next = S_WAIT_USR;
`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
        else if (w_timer_zero) w_fail = 1'b1;
`endif
      end
      S_WAIT_USR: begin
        if (w_usr) w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_timer_zero) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_cal_fail || !w_usr) w_fail = 1'b1;
      end
      S_BACKOFF: begin
        if (w_timer_zero) w_state_next = S_RESET_REQ;
      end
      S_FAIL: begin
        w_state_next = S_FAIL;
      end
      default: begin
        w_state_next = S_WAIT_PLL;
      end
    endcase

    if (w_fail) begin
      w_state_next = (w_retry_sat < MAX_R) ? S_BACKOFF : S_FAIL;
    end

    // PLL loss is a clock problem, not a calibration failure, so it does not count as a retry.
    if (!w_pll && (r_state != S_WAIT_PLL) && (r_state != S_FAIL)) begin
      w_state_next = S_WAIT_PLL;
      w_fail       = 1'b0;
    end

    if (restart_i) begin
      w_state_next = S_WAIT_PLL;
      w_fail       = 1'b0;
    end
  end

  always_comb begin
    w_retry_next = r_retry;
    if (restart_i) begin
      w_retry_next = 4'd0;
    end else if (w_fail) begin
      w_retry_next = w_retry_sat;
    end
  end

  always_comb begin
    w_timer_load = '0;
    case (w_state_next)
      S_RESET_REQ: w_timer_load = LD_REQ;
      S_SETTLE:    w_timer_load = LD_SETTLE;
      S_BACKOFF:   w_timer_load = LD_BACKOFF;
`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
      S_WAIT_DONE: w_timer_load = LD_CAL;
      S_WAIT_CAL:  w_timer_load = LD_CAL;
`endif
      default:     w_timer_load = '0;
    endcase
  end

  always_comb begin
    w_timer_next = r_timer;
    if (w_state_next != r_state) begin
      w_timer_next = w_timer_load;
    end else if (!w_timer_zero) begin
      w_timer_next = r_timer - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_WAIT_PLL;
      r_timer     <= '0;
      r_retry     <= 4'd0;
      r_req       <= 1'b0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_retry     <= w_retry_next;
      r_req       <= (w_state_next == S_RESET_REQ);
      r_sys_rst_n <= (w_state_next == S_RUN);
      r_ready     <= (w_state_next == S_RUN);
      r_error     <= (w_state_next == S_FAIL);
    end
  end

  assign local_reset_req_o = r_req;
  assign sys_rst_no        = r_sys_rst_n;
  assign ready_o           = r_ready;
  assign error_o           = r_error;
  assign retry_cnt_o       = r_retry;
  assign state_o           = r_state;

endmodule

// File: tb/tb_emif_init_sequencer.sv
// Directed self-checking bench for emif_init_sequencer: bring-up, retries, exhaustion, PLL loss,
// timeout and mid-operation reset, with hand-computed expectations for the small bench parameters.
module tb_emif_init_sequencer;

  logic       clk_i;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       local_reset_done_i;
  logic       cal_success_i;
  logic       cal_fail_i;
  logic       usr_reset_n_i;
  logic       restart_i;
  logic       local_reset_req_o;
  logic       sys_rst_no;
  logic       ready_o;
  logic       error_o;
  logic [3:0] retry_cnt_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  emif_init_sequencer #(
    .REQ_PULSE     (4),
    .CAL_TIMEOUT   (100),
    .SETTLE_CYCLES (8),
    .BACKOFF_CYCLES(16),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pll_locked_i      (pll_locked_i),
    .local_reset_done_i(local_reset_done_i),
    .cal_success_i     (cal_success_i),
    .cal_fail_i        (cal_fail_i),
    .usr_reset_n_i     (usr_reset_n_i),
    .restart_i         (restart_i),
    .local_reset_req_o (local_reset_req_o),
    .sys_rst_no        (sys_rst_no),
    .ready_o           (ready_o),
    .error_o           (error_o),
    .retry_cnt_o       (retry_cnt_o),
    .state_o           (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    int i = 0;
    while (state_o !== s && i < budget) begin
      tick();
      i++;
    end
    ok = (state_o === s);
  endtask

  task automatic emif_quiet();
    local_reset_done_i = 1'b0;
    cal_success_i      = 1'b0;
    cal_fail_i         = 1'b0;
    usr_reset_n_i      = 1'b0;
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (local_reset_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", local_reset_req_o); end
    checks++; if (sys_rst_no !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_no); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error_o); end
    checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt_o); end
    rst_ni = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    bit ok;
    int n;
    repeat (10) tick();
    pll_locked_i = 1'b1;
    wait_state(4'd1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_enter_req: got state %0d want 1", state_o); end
    n = 0;
    while (local_reset_req_o === 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL nom_req_width: got %0d want 4", n); end
    repeat (5) tick();
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_wait_cal: got state %0d want 3", state_o); end
    repeat (20) tick();
    cal_success_i = 1'b1;
    wait_state(4'd4, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_wait_usr: got state %0d want 4", state_o); end
    repeat (3) tick();
    usr_reset_n_i = 1'b1;
    wait_state(4'd5, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_settle: got state %0d want 5", state_o); end
    n = 0;
    while (sys_rst_no !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL nom_settle_len: got %0d want 8", n); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL nom_ready: got %b want 1", ready_o); end
    checks++; if (state_o !== 4'd6) begin errors++; $display("FAIL nom_run_state: got %0d want 6", state_o); end
    checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL nom_retry: got %0d want 0", retry_cnt_o); end
    $display("test_nominal done");
  endtask

  task automatic test_retry_success();
    bit ok;
    int n;
    emif_quiet();
    pulse_restart();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rs_restart_state: got %0d want 0", state_o); end
    checks++; if (sys_rst_no !== 1'b0) begin errors++; $display("FAIL rs_restart_sys: got %b want 0", sys_rst_no); end
    wait_state(4'd2, 30, ok);
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 20, ok);
    cal_fail_i = 1'b1;
    wait_state(4'd7, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_backoff: got state %0d want 7", state_o); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL rs_retry1: got %0d want 1", retry_cnt_o); end
    cal_fail_i = 1'b0;
    local_reset_done_i = 1'b0;
    n = 0;
    while (state_o === 4'd7 && n < 100) begin tick(); n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL rs_backoff_len: got %0d want 16", n); end
    checks++; if (local_reset_req_o !== 1'b1) begin errors++; $display("FAIL rs_second_req: got %b want 1", local_reset_req_o); end
    wait_state(4'd2, 20, ok);
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 20, ok);
    cal_success_i = 1'b1;
    wait_state(4'd4, 20, ok);
    usr_reset_n_i = 1'b1;
    wait_state(4'd6, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_run: got state %0d want 6", state_o); end
    checks++; if (sys_rst_no !== 1'b1) begin errors++; $display("FAIL rs_sys: got %b want 1", sys_rst_no); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL rs_retry_kept: got %0d want 1", retry_cnt_o); end
    $display("test_retry_success done");
  endtask

  task automatic test_exhausted();
    bit ok;
    emif_quiet();
    pulse_restart();
    local_reset_done_i = 1'b1;
    cal_fail_i = 1'b1;
    wait_state(4'd8, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ex_fail_state: got %0d want 8", state_o); end
    repeat (5) tick();
    checks++; if (state_o !== 4'd8) begin errors++; $display("FAIL ex_fail_hold: got %0d want 8", state_o); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL ex_error: got %b want 1", error_o); end
    checks++; if (sys_rst_no !== 1'b0) begin errors++; $display("FAIL ex_sys: got %b want 0", sys_rst_no); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ex_ready: got %b want 0", ready_o); end
    checks++; if (retry_cnt_o !== 4'd2) begin errors++; $display("FAIL ex_retry: got %0d want 2", retry_cnt_o); end
    emif_quiet();
    pulse_restart();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL ex_restart_state: got %0d want 0", state_o); end
    checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL ex_restart_retry: got %0d want 0", retry_cnt_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ex_restart_error: got %b want 0", error_o); end
    $display("test_exhausted done");
  endtask

  task automatic test_simultaneous();
    bit ok;
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 40, ok);
    cal_success_i = 1'b1;
    cal_fail_i    = 1'b1;
    wait_state(4'd7, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_backoff: got state %0d want 7", state_o); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL sim_retry: got %0d want 1", retry_cnt_o); end
    $display("test_simultaneous done");
  endtask

  task automatic test_pll_loss();
    bit ok;
    int n;
    cal_fail_i    = 1'b0;
    usr_reset_n_i = 1'b1;
    wait_state(4'd6, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pll_run: got state %0d want 6", state_o); end
    pll_locked_i = 1'b0;
    n = 0;
    while ((state_o !== 4'd0 || sys_rst_no !== 1'b0) && n < 10) begin tick(); n++; end
    checks++; if (n > 3) begin errors++; $display("FAIL pll_drop_latency: got %0d want <=3", n); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL pll_retry: got %0d want 1", retry_cnt_o); end
    emif_quiet();
    repeat (5) tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL pll_hold: got %0d want 0", state_o); end
    pll_locked_i = 1'b1;
    wait_state(4'd1, 10, ok);
    n = 0;
    while (local_reset_req_o === 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL pll_relock_req: got %0d want 4", n); end
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 20, ok);
    cal_success_i = 1'b1;
    wait_state(4'd4, 20, ok);
    usr_reset_n_i = 1'b1;
    wait_state(4'd6, 50, ok);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL pll_relock_ready: got %b want 1", ready_o); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL pll_relock_retry: got %0d want 1", retry_cnt_o); end
    $display("test_pll_loss done");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    emif_quiet();
    pulse_restart();
    wait_state(4'd2, 30, ok);
    local_reset_done_i = 1'b1;
    wait_state(4'd3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait_cal: got state %0d want 3", state_o); end
    n = 0;
    while (state_o === 4'd3 && n < 1000) begin tick(); n++; end
`ifdef EMIF_SEQ_CAL_TIMEOUT_EN
    checks++; if (n != 100) begin errors++; $display("FAIL to_len: got %0d want 100", n); end
    checks++; if (state_o !== 4'd7) begin errors++; $display("FAIL to_backoff: got %0d want 7", state_o); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL to_retry: got %0d want 1", retry_cnt_o); end
`else
    checks++; if (n != 1000) begin errors++; $display("FAIL to_len: got %0d want 1000", n); end
    checks++; if (state_o !== 4'd3) begin errors++; $display("FAIL to_still_cal: got %0d want 3", state_o); end
`endif
    $display("test_timeout done");
  endtask

  task automatic test_reset_midop();
    bit ok;
    emif_quiet();
    pulse_restart();
    local_reset_done_i = 1'b1;
    cal_fail_i = 1'b1;
    wait_state(4'd7, 50, ok);
    cal_fail_i = 1'b0;
    local_reset_done_i = 1'b0;
    wait_state(4'd1, 30, ok);
    checks++; if (local_reset_req_o !== 1'b1) begin errors++; $display("FAIL mid_req_high: got %b want 1", local_reset_req_o); end
    checks++; if (retry_cnt_o !== 4'd1) begin errors++; $display("FAIL mid_retry_pre: got %0d want 1", retry_cnt_o); end
    rst_ni = 1'b0;
    tick();
    checks++; if (local_reset_req_o !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", local_reset_req_o); end
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state_o); end
    checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL mid_retry: got %0d want 0", retry_cnt_o); end
    rst_ni = 1'b1;
    $display("test_reset_midop done");
  endtask

  initial begin
    rst_ni = 1'b0;
    pll_locked_i = 1'b0;
    restart_i = 1'b0;
    emif_quiet();
    test_reset();
    test_nominal();
    test_retry_success();
    test_exhausted();
    test_simultaneous();
    test_pll_loss();
    test_timeout();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/emif_init_sequencer.md
Name: emif_init_sequencer

Overview:
- Bring-up and recovery sequencer for the DDR4 EMIF on the Intel FPGA platform.
- Waits for IOPLL lock, issues the EMIF local reset request, and tracks reset-done and calibration status.
- Retries failed calibration with backoff, then releases the system reset to the CVA6 SoC once memory is usable.
- Sits between the EMIF status pins and the reset controller input; runs on the free-running reference-derived clock.

Parameters:
- REQ_PULSE, 16: cycles local_reset_req_o is held high per request.
- CAL_TIMEOUT, 1048576: max cycles in WAIT_CAL before a timeout counts as failure.
- SETTLE_CYCLES, 64: cycles after EMIF user reset release before sys_rst_no deasserts.
- BACKOFF_CYCLES, 1024: idle cycles between a failure and the next request.
- MAX_RETRIES, 3: failed attempts allowed before FAIL; range 1..15.
- SYNC_STAGES, 2: flop stages on each status input; minimum 2.

Ports:
- clk_i  in  1  sequencer clock.
- rst_ni  in  1  synchronous active-low reset.
- pll_locked_i  in  1  EMIF PLL locked, asynchronous.
- local_reset_done_i  in  1  EMIF local reset complete, asynchronous.
- cal_success_i  in  1  EMIF calibration success, asynchronous.
- cal_fail_i  in  1  EMIF calibration fail, asynchronous.
- usr_reset_n_i  in  1  EMIF user-domain reset_n, asynchronous.
- restart_i  in  1  software/debug restart pulse, synchronous to clk_i.
- local_reset_req_o  out  1  EMIF local reset request.
- sys_rst_no  out  1  SoC reset, active-low, registered.
- ready_o  out  1  high only in RUN.
- error_o  out  1  high only in FAIL.
- retry_cnt_o  out  4  failed attempts since last reset or restart.
- state_o  out  4  current state encoding.

Behaviour:
- Input synchronisation:
  - Every asynchronous input passes through SYNC_STAGES flops before use.
  - All latencies below are counted from the synchronised value.
  - Synchroniser flops reset to 0.
- Reset values (rst_ni=0 at a clock edge):
  - state=WAIT_PLL, local_reset_req_o=0, sys_rst_no=0, ready_o=0, error_o=0, retry_cnt_o=0.
  - Timer cleared.
  - Reset mid-operation aborts immediately; req drops on the same edge.
- States and encodings:
  - WAIT_PLL (0): leave when pll_locked=1, go to RESET_REQ and load timer.
  - RESET_REQ (1): local_reset_req_o=1 for exactly REQ_PULSE cycles, then WAIT_DONE.
  - WAIT_DONE (2): go to WAIT_CAL when local_reset_done=1 and timer is loaded.
  - WAIT_CAL (3):
    - cal_fail=1: failure path. If cal_fail and cal_success are high together, fail wins.
    - cal_success=1 with cal_fail=0: go to WAIT_USR.
  - WAIT_USR (4): go to SETTLE when usr_reset_n=1.
  - SETTLE (5): count SETTLE_CYCLES, then RUN.
  - RUN (6):
    - sys_rst_no=1 and ready_o=1, both registered and asserted on the RUN entry edge.
    - cal_fail=1 or usr_reset_n=0: failure path; sys_rst_no=0 on the next edge.
  - BACKOFF (7): count BACKOFF_CYCLES, then RESET_REQ.
  - FAIL (8): error_o=1, sys_rst_no=0; exited only by rst_ni or restart_i.
- Failure path:
  - retry_cnt increments, saturating at 15.
  - If the new count < MAX_RETRIES, go to BACKOFF; otherwise go to FAIL.
- PLL loss:
  - pll_locked=0 in any state except WAIT_PLL and FAIL forces WAIT_PLL.
  - req drops to 0 and sys_rst_no=0.
  - retry_cnt is not incremented.
- restart_i:
  - Sampled 1 in any state: WAIT_PLL next edge, retry_cnt=0, req=0, sys_rst_no=0.
  - Takes priority over every other transition.
- Timer:
  - One shared down-counter, width clog2 of the largest of REQ_PULSE, CAL_TIMEOUT, SETTLE_CYCLES and BACKOFF_CYCLES, plus 1.
  - Loaded on each state entry; never wraps, holds at 0.
- sys_rst_no is 0 in every state except RUN.

Optional Feature:
- Macro: EMIF_SEQ_CAL_TIMEOUT_EN.
- Defined:
  - WAIT_CAL and WAIT_DONE time out after CAL_TIMEOUT cycles with no exit condition.
  - A timeout takes the failure path.
- Undefined:
  - Both states wait indefinitely.
  - CAL_TIMEOUT is unused and the timer is sized without it.

Test Plan (bench parameters REQ_PULSE=4, SETTLE_CYCLES=8, BACKOFF_CYCLES=16, CAL_TIMEOUT=100, MAX_RETRIES=2, SYNC_STAGES=2):
- Nominal bring-up:
  - Stimulus: pll_locked at cycle 10, reset_done 5 cycles after req falls, cal_success 20 cycles later, usr_reset_n 3 cycles later.
  - Required: req high exactly 4 cycles; sys_rst_no rises exactly 8 cycles after synchronised usr_reset_n; ready_o=1; retry_cnt_o=0.
- Retry then success:
  - Stimulus: cal_fail on first attempt, cal_success on second.
  - Required: retry_cnt_o=1; 16 backoff cycles between req pulses; RUN reached.
- Exhausted retries:
  - Stimulus: cal_fail on two attempts.
  - Required: state_o=8, error_o=1, sys_rst_no=0; restart_i pulse gives state_o=0 and retry_cnt_o=0.
- Simultaneous cal_success and cal_fail in WAIT_CAL -> failure path taken, retry_cnt_o=1.
- PLL loss:
  - Stimulus: pll_locked drops in RUN.
  - Required: sys_rst_no=0 and state_o=0 within SYNC_STAGES+1 cycles; retry_cnt_o unchanged; after relock, full sequence repeats.
- Timeout with EMIF_SEQ_CAL_TIMEOUT_EN defined:
  - Stimulus: no cal status.
  - Required: BACKOFF entered exactly 100 cycles after WAIT_CAL entry; without the macro, still in WAIT_CAL at cycle 1000.
